// File: rtl/mult_issue_ctrl_pkg.sv
// Shared types and constants for the multdiv issue controllers.
// State encoding and status-register exception codes.
package mult_issue_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } mic_state_e;

  localparam int MD_STATUS_REG = 30;
  localparam int MD_OVF_CODE   = 1;
  localparam int MD_TMO_CODE   = 2;

endpackage

// File: rtl/mult_wb_mux.sv
// Writeback packet selection for the multiplier issue controller.
// Exceptions redirect the write to the status register.
module mult_wb_mux
  import mult_issue_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = MD_STATUS_REG,
  parameter int OVF_CODE   = MD_OVF_CODE,
  parameter int TMO_CODE   = MD_TMO_CODE
) (
  input  logic [REG_W-1:0]  rd,
  input  logic [DATA_W-1:0] result,
  input  logic              ovf,
  input  logic              tmo,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exception
);

  always_comb begin
    wb_rd        = rd;
    wb_data      = result;
    wb_exception = 1'b0;
    unique case (1'b1)
      tmo: begin
        wb_rd        = REG_W'(STATUS_REG);
        wb_data      = DATA_W'(TMO_CODE);
        wb_exception = 1'b1;
      end
      ovf: begin
        wb_rd        = REG_W'(STATUS_REG);
        wb_data      = DATA_W'(OVF_CODE);
        wb_exception = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mult_issue_ctrl.sv
// Issue/writeback controller in front of the multi-cycle multiplier.
// One op in flight; stalls the pipe until the packet is taken.
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int STATUS_REG = MD_STATUS_REG,
  parameter int OVF_CODE   = MD_OVF_CODE,
  parameter int TMO_CODE   = MD_TMO_CODE,
  parameter int TIMEOUT    = 40,
  parameter int READY_MASK = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [REG_W-1:0]  req_rd,
  input  logic              flush,
  output logic              mul_start,
  output logic [DATA_W-1:0] mul_operand_a,
  output logic [DATA_W-1:0] mul_operand_b,
  input  logic              mul_ready,
  input  logic [DATA_W-1:0] mul_result,
  input  logic              mul_overflow,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              wb_exception,
  output logic              stall
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TMO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MASK = CNT_W'(READY_MASK);

  mic_state_e state_q, state_d;

  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] a_q, b_q, res_q;
  logic [REG_W-1:0]  rd_q;
  logic              ovf_q, tmo_q;
  logic              accept, rdy_ok, tmo_hit;

  assign accept  = req_valid && req_ready;
  // early ready is a stale level from the previous op
  assign rdy_ok  = mul_ready && (cnt_q >= CNT_MASK);
  assign tmo_hit = !rdy_ok && (cnt_q == CNT_TMO);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (accept) state_d = LAUNCH;
      LAUNCH: state_d = flush ? IDLE : BUSY;
      BUSY: begin
        if (flush)                   state_d = IDLE;
        else if (rdy_ok || tmo_hit)  state_d = DONE;
      end
      DONE:   if (wb_ready) state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mul_start = 1'b0;
    wb_valid  = 1'b0;
    stall     = 1'b0;
    unique case (state_q)
      IDLE:   req_ready = !flush && reset_n;
      LAUNCH: begin
        mul_start = 1'b1;
        stall     = 1'b1;
      end
      BUSY:   stall = 1'b1;
      DONE: begin
        wb_valid = 1'b1;
        stall    = !wb_ready;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      a_q   <= '0;
      b_q   <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      if (accept) begin
        a_q  <= req_a;
        b_q  <= req_b;
        rd_q <= req_rd;
      end
      if (state_q == LAUNCH)    cnt_q <= '0;
      else if (state_q == BUSY) cnt_q <= cnt_q + CNT_W'(1);
      if (state_q == BUSY && !flush) begin
        if (rdy_ok) begin
          res_q <= mul_result;
          ovf_q <= mul_overflow;
          tmo_q <= 1'b0;
        end else if (tmo_hit) begin
          res_q <= '0;
          ovf_q <= 1'b0;
          tmo_q <= 1'b1;
        end
      end
    end
  end

  assign mul_operand_a = a_q;
  assign mul_operand_b = b_q;

  mult_wb_mux #(
    .DATA_W     (DATA_W),
    .REG_W      (REG_W),
    .STATUS_REG (STATUS_REG),
    .OVF_CODE   (OVF_CODE),
    .TMO_CODE   (TMO_CODE)
  ) u_wb_mux (
    .rd           (rd_q),
    .result       (res_q),
    .ovf          (ovf_q),
    .tmo          (tmo_q),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .wb_exception (wb_exception)
  );

endmodule
